mem_unit: RTL and testbench

Memory-stage access unit for the 5-stage MIPS pipeline. It consumes the MEM-stage control signals (`MEMWr`, `MEMOp`, `loadSignExt`) produced by the decoder, together with the ALU address and the store data. It then runs a request/acknowledge transaction to a word-wide, variable-latency data memory and returns the extended load result to the write-back path. While an access is outstanding it holds the pipeline with `stall`, and it flags misaligned or timed-out accesses.

---
 rtl/mem_unit_if.sv | 21 ++
 rtl/mem_unit.sv | 200 ++++++++++++++++++++
 tb/tb_mem_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_unit_if.sv
// Data-memory request/acknowledge bus between mem_unit (master) and a word-wide,
// variable-latency data memory (slave).
interface mem_unit_if;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/mem_unit.sv
// MEM-stage access unit: runs one req/ack transaction per load/store, stalls the
// pipeline while it is outstanding, and flags misaligned or timed-out accesses.
module mem_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        MEMWr,
  input  logic [1:0]  MEMOp,
  input  logic        loadSignExt,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        addr_err,
  output logic        bus_err,
  output logic        err_sticky,
  output logic [31:0] err_addr,
  mem_unit_if.master  dm
);

  // def.v encodings
  localparam logic [1:0] MEMOP_BYTE     = 2'b00;
  localparam logic [1:0] MEMOP_HALFWORD = 2'b01;
  localparam logic [1:0] MEMOP_WORD     = 2'b10;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [15:0] TimeoutW = 16'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        sext_q, sext_d;
  logic [31:0] addr_q, addr_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        ld_valid_q, ld_valid_d;
  logic        addr_err_q, addr_err_d;
  logic        bus_err_q, bus_err_d;
  logic        err_sticky_q, err_sticky_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic        aligned;
  logic [3:0]  be_new;
  logic [31:0] wdata_masked;
  logic [31:0] rd_shift;
  logic [31:0] ld_ext;
  logic [15:0] cnt_inc;

  always_comb begin
    aligned      = 1'b1;
    be_new       = 4'b1111;
    wdata_masked = wdata;
    case (MEMOp)
      MEMOP_BYTE: begin
        be_new       = 4'b0001 << addr[1:0];
        wdata_masked = {24'b0, wdata[7:0]};
      end
      MEMOP_HALFWORD: begin
        aligned      = ~addr[0];
        be_new       = 4'b0011 << addr[1:0];
        wdata_masked = {16'b0, wdata[15:0]};
      end
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  // Alignment guarantees a halfword lane is addr[1]*2 and a word lane is 0,
  // so one right shift by the byte offset serves all sizes.
  always_comb begin
    rd_shift = dm.dm_rdata >> {addr_q[1:0], 3'b000};
    case (op_q)
      MEMOP_BYTE:     ld_ext = {{24{sext_q & rd_shift[7]}}, rd_shift[7:0]};
      MEMOP_HALFWORD: ld_ext = {{16{sext_q & rd_shift[15]}}, rd_shift[15:0]};
      default:        ld_ext = rd_shift;
    endcase
  end

  assign cnt_inc = cnt_q + 16'd1;
  assign stall   = ((state_q == StIdle) & req_valid & aligned) | (state_q == StWait);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    sext_d       = sext_q;
    addr_d       = addr_q;
    dm_req_d     = dm_req_q;
    dm_we_d      = dm_we_q;
    dm_be_d      = dm_be_q;
    dm_wdata_d   = dm_wdata_q;
    ld_data_d    = ld_data_q;
    ld_valid_d   = 1'b0;
    addr_err_d   = 1'b0;
    bus_err_d    = 1'b0;
    err_sticky_d = err_sticky_q;
    err_addr_d   = err_addr_q;
    case (state_q)
      StIdle: begin
        if (req_valid && aligned) begin
          state_d    = StWait;
          cnt_d      = 16'd0;
          op_d       = MEMOp;
          sext_d     = loadSignExt;
          addr_d     = addr;
          dm_req_d   = 1'b1;
          dm_we_d    = MEMWr;
          dm_be_d    = be_new;
          dm_wdata_d = wdata_masked << {addr[1:0], 3'b000};
        end else if (req_valid) begin
          addr_err_d   = 1'b1;
          err_sticky_d = 1'b1;
          err_addr_d   = addr;
        end
      end
      StWait: begin
        // An ack in the same cycle the counter expires still completes normally.
        if (dm.dm_ack) begin
          state_d  = StDone;
          dm_req_d = 1'b0;
          dm_we_d  = 1'b0;
          dm_be_d  = 4'b0000;
          if (!dm_we_q) begin
            ld_data_d  = ld_ext;
            ld_valid_d = 1'b1;
          end
        end else if (cnt_inc == TimeoutW) begin
          state_d      = StDone;
          dm_req_d     = 1'b0;
          dm_we_d      = 1'b0;
          dm_be_d      = 4'b0000;
          ld_data_d    = 32'd0;
          bus_err_d    = 1'b1;
          err_sticky_d = 1'b1;
          err_addr_d   = addr_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      cnt_q        <= 16'd0;
      op_q         <= 2'b00;
      sext_q       <= 1'b0;
      addr_q       <= 32'd0;
      dm_req_q     <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_be_q      <= 4'b0000;
      dm_wdata_q   <= 32'd0;
      ld_data_q    <= 32'd0;
      ld_valid_q   <= 1'b0;
      addr_err_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_addr_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      sext_q       <= sext_d;
      addr_q       <= addr_d;
      dm_req_q     <= dm_req_d;
      dm_we_q      <= dm_we_d;
      dm_be_q      <= dm_be_d;
      dm_wdata_q   <= dm_wdata_d;
      ld_data_q    <= ld_data_d;
      ld_valid_q   <= ld_valid_d;
      addr_err_q   <= addr_err_d;
      bus_err_q    <= bus_err_d;
      err_sticky_q <= err_sticky_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign dm.dm_req   = dm_req_q;
  assign dm.dm_we    = dm_we_q;
  assign dm.dm_be    = dm_be_q;
  assign dm.dm_addr  = {addr_q[31:2], 2'b00};
  assign dm.dm_wdata = dm_wdata_q;
  assign ld_data     = ld_data_q;
  assign ld_valid    = ld_valid_q;
  assign addr_err    = addr_err_q;
  assign bus_err     = bus_err_q;
  assign err_sticky  = err_sticky_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit: loads/stores of every size, misalignment, timeout,
// ack/timeout coincidence and reset while a request is outstanding.
module tb_mem_unit;

  localparam logic [1:0] OpB = 2'b00;
  localparam logic [1:0] OpH = 2'b01;
  localparam logic [1:0] OpW = 2'b10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        MEMWr = 1'b0;
  logic [1:0]  MEMOp = 2'b00;
  logic        loadSignExt = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        addr_err;
  logic        bus_err;
  logic        err_sticky;
  logic [31:0] err_addr;

  mem_unit_if dm_if ();

  mem_unit #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .MEMWr       (MEMWr),
    .MEMOp       (MEMOp),
    .loadSignExt (loadSignExt),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .ld_data     (ld_data),
    .ld_valid    (ld_valid),
    .addr_err    (addr_err),
    .bus_err     (bus_err),
    .err_sticky  (err_sticky),
    .err_addr    (err_addr),
    .dm          (dm_if)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Results captured by run_access.
  int          r_stalls;
  int          r_reqs;
  logic [3:0]  r_be;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_ld;
  logic        r_lv;
  logic        r_berr;
  logic        r_stable;
  logic        r_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction; n = WAIT cycle (1-based) in which dm_ack is given, 0 = never.
  task automatic run_access(input logic we, input logic [1:0] op, input logic sx,
                            input logic [31:0] a, input logic [31:0] wd, input int n,
                            input logic [31:0] rd);
    @(posedge clk); #1;
    req_valid = 1'b1; MEMWr = we; MEMOp = op; loadSignExt = sx; addr = a; wdata = wd;
    @(negedge clk);
    r_stalls = stall ? 1 : 0;
    r_reqs = 0; r_done = 1'b0; r_stable = 1'b1; r_lv = 1'b0; r_berr = 1'b0; r_ld = '0;
    @(posedge clk); #1;
    // Inputs must be ignored while the access is outstanding.
    req_valid = 1'b0; MEMWr = ~we; MEMOp = OpB; loadSignExt = ~sx;
    addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF;
    for (int k = 1; k <= 20 && !r_done; k++) begin
      dm_if.dm_ack = (k == n);
      dm_if.dm_rdata = (k == n) ? rd : 32'h1357_9BDF;
      @(negedge clk);
      if (dm_if.dm_req) r_reqs++;
      if (!stall) begin
        r_done = 1'b1; r_ld = ld_data; r_lv = ld_valid; r_berr = bus_err;
      end else begin
        r_stalls++;
        if (k == 1) begin
          r_be = dm_if.dm_be; r_we = dm_if.dm_we; r_addr = dm_if.dm_addr;
          r_wdata = dm_if.dm_wdata;
        end else if (dm_if.dm_be !== r_be || dm_if.dm_we !== r_we ||
                     dm_if.dm_addr !== r_addr || dm_if.dm_wdata !== r_wdata) begin
          r_stable = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    dm_if.dm_ack = 1'b0;
    chk("access_completes", 32'(r_done), 32'd1);
  endtask

  initial begin
    dm_if.dm_ack = 1'b0;
    dm_if.dm_rdata = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_dm_req", 32'(dm_if.dm_req), 32'd0);
    chk("rst_dm_be", 32'(dm_if.dm_be), 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    rstn = 1'b1;

    // LW 0x100, zero-wait memory
    run_access(1'b0, OpW, 1'b0, 32'h0000_0100, 32'd0, 1, 32'hDEAD_BEEF);
    chk("lw_be", 32'(r_be), 32'hF);
    chk("lw_we", 32'(r_we), 32'd0);
    chk("lw_dm_addr", r_addr, 32'h0000_0100);
    chk("lw_ld_data", r_ld, 32'hDEAD_BEEF);
    chk("lw_ld_valid", 32'(r_lv), 32'd1);
    chk("lw_stalls", 32'(r_stalls), 32'd2);
    chk("lw_req_cycles", 32'(r_reqs), 32'd1);
    chk("lw_ld_valid_pulse", 32'(ld_valid), 32'd0);

    // LB / LBU / LHU on 0x80FF1234
    run_access(1'b0, OpB, 1'b1, 32'h0000_0103, 32'd0, 1, 32'h80FF_1234);
    chk("lb_ld_data", r_ld, 32'hFFFF_FF80);
    chk("lb_be", 32'(r_be), 32'h8);
    run_access(1'b0, OpB, 1'b0, 32'h0000_0103, 32'd0, 1, 32'h80FF_1234);
    chk("lbu_ld_data", r_ld, 32'h0000_0080);
    run_access(1'b0, OpH, 1'b0, 32'h0000_0102, 32'd0, 1, 32'h80FF_1234);
    chk("lhu_ld_data", r_ld, 32'h0000_80FF);
    chk("lhu_be", 32'(r_be), 32'hC);
    run_access(1'b0, OpH, 1'b1, 32'h0000_0100, 32'd0, 2, 32'h80FF_9234);
    chk("lh_ld_data", r_ld, 32'hFFFF_9234);

    // SH 0x202 with 3 WAIT cycles, SB 0x201
    run_access(1'b1, OpH, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 3, 32'd0);
    chk("sh_we", 32'(r_we), 32'd1);
    chk("sh_be", 32'(r_be), 32'hC);
    chk("sh_wdata_hi", 32'(r_wdata[31:16]), 32'h0000_ABCD);
    chk("sh_dm_addr", r_addr, 32'h0000_0200);
    chk("sh_stalls", 32'(r_stalls), 32'd4);
    chk("sh_held_stable", 32'(r_stable), 32'd1);
    chk("sh_no_ld_valid", 32'(r_lv), 32'd0);
    run_access(1'b1, OpB, 1'b0, 32'h0000_0201, 32'h0000_005A, 1, 32'd0);
    chk("sb_be", 32'(r_be), 32'h2);
    chk("sb_wdata_b1", 32'(r_wdata[15:8]), 32'h5A);

    // Ack in the very cycle the counter would expire: ack wins
    run_access(1'b0, OpW, 1'b0, 32'h0000_0300, 32'd0, 4, 32'h1122_3344);
    chk("coinc_ld_data", r_ld, 32'h1122_3344);
    chk("coinc_bus_err", 32'(r_berr), 32'd0);
    chk("coinc_stalls", 32'(r_stalls), 32'd5);
    chk("coinc_sticky", 32'(err_sticky), 32'd0);

    // Misaligned LW 0x102
    @(posedge clk); #1;
    req_valid = 1'b1; MEMWr = 1'b0; MEMOp = OpW; addr = 32'h0000_0102;
    @(negedge clk);
    chk("mis_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mis_addr_err", 32'(addr_err), 32'd1);
    chk("mis_err_addr", err_addr, 32'h0000_0102);
    chk("mis_sticky", 32'(err_sticky), 32'd1);
    chk("mis_no_req", 32'(dm_if.dm_req), 32'd0);
    chk("mis_no_ld_valid", 32'(ld_valid), 32'd0);
    chk("mis_no_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("mis_pulse_end", 32'(addr_err), 32'd0);

    // Misaligned SH 0x201 is dropped
    @(posedge clk); #1;
    req_valid = 1'b1; MEMWr = 1'b1; MEMOp = OpH; addr = 32'h0000_0201;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mis_sh_addr_err", 32'(addr_err), 32'd1);
    chk("mis_sh_err_addr", err_addr, 32'h0000_0201);
    chk("mis_sh_no_we", 32'(dm_if.dm_we), 32'd0);

    // Timeout (TIMEOUT = 4)
    run_access(1'b0, OpW, 1'b0, 32'h0000_0400, 32'd0, 0, 32'd0);
    chk("to_req_cycles", 32'(r_reqs), 32'd4);
    chk("to_stalls", 32'(r_stalls), 32'd5);
    chk("to_bus_err", 32'(r_berr), 32'd1);
    chk("to_ld_data", r_ld, 32'd0);
    chk("to_ld_valid", 32'(r_lv), 32'd0);
    chk("to_err_addr", err_addr, 32'h0000_0400);
    chk("to_bus_err_pulse", 32'(bus_err), 32'd0);

    // Reset while WAIT
    @(posedge clk); #1;
    req_valid = 1'b1; MEMWr = 1'b0; MEMOp = OpW; addr = 32'h0000_0500;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rw_req_before", 32'(dm_if.dm_req), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rw_dm_req", 32'(dm_if.dm_req), 32'd0);
    chk("rw_stall", 32'(stall), 32'd0);
    chk("rw_sticky", 32'(err_sticky), 32'd0);
    chk("rw_err_addr", err_addr, 32'd0);
    chk("rw_ld_data", ld_data, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    run_access(1'b0, OpW, 1'b0, 32'h0000_0104, 32'd0, 2, 32'hCAFE_F00D);
    chk("rw_fresh_ld", r_ld, 32'hCAFE_F00D);
    chk("rw_fresh_valid", 32'(r_lv), 32'd1);
    chk("rw_fresh_stalls", 32'(r_stalls), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
